// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding, ALU op codes and PC step for the multi-cycle controller
package ctrl_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;
  localparam logic [3:0] OP_AND         = 4'b0000;
  localparam logic [3:0] OP_OR          = 4'b0001;
  localparam logic [3:0] OP_ADD         = 4'b0010;
  localparam logic [3:0] OP_SUB         = 4'b0110;
  localparam logic [3:0] OP_SLT         = 4'b0111;
  localparam logic [3:0] OP_NOR         = 4'b1100;
  localparam logic [3:0] OP_NOT_DEFINED = 4'b1111;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (en && q != '1) q <= q + WIDTH'(1);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/WB sequencer with imem handshake, strobes and retire count
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic [DWIDTH-1:0] ir,
  input  logic [3:0]        op_in,
  input  logic [4:0]        rdst_id,
  input  logic              stall,
  output logic              opnd_le,
  output logic              alu_le,
  output logic              rf_we,
  output logic [DWIDTH-1:0] pc,
  output logic              halted,
  output logic [31:0]       retired
);
  state_t state, state_nxt;
  logic fetch_done, wb_done;
  assign fetch_done = state == FETCH && imem_req && imem_ack;
  assign wb_done    = state == WB && !stall;
  assign imem_addr  = pc;
  assign halted     = state == HALT;
  always_ff @(posedge clk)
    if (rst) begin
      state    <= FETCH;
      pc       <= PC_RESET;
      ir       <= '0;
      imem_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      imem_req <= (state == FETCH && !fetch_done) || wb_done;
      if (fetch_done) begin
        ir <= imem_rdata;
        pc <= pc + DWIDTH'(PC_STEP);
      end
    end
  always_comb begin
    state_nxt = state;
    opnd_le   = 1'b0;
    alu_le    = 1'b0;
    rf_we     = 1'b0;
    unique case (state)
      FETCH:  state_nxt = fetch_done ? DECODE : FETCH;
      DECODE: begin
        opnd_le   = op_in != OP_NOT_DEFINED && !stall;
        state_nxt = op_in == OP_NOT_DEFINED ? HALT : stall ? DECODE : EXEC;
      end
      EXEC: begin
        alu_le    = !stall;
        state_nxt = stall ? EXEC : WB;
      end
      WB: begin
        rf_we     = !stall && rdst_id != 5'd0;
        state_nxt = stall ? WB : FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end
  sat_counter #(.WIDTH(32)) u_retired (
    .clk (clk),
    .clr (rst),
    .en  (wb_done),
    .q   (retired)
  );
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven instruction runs with a retire scoreboard plus halt/reset corner sequences
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst, imem_ack, stall;
  logic [31:0] imem_rdata;
  logic [3:0] op_in;
  logic [4:0] rdst_id;
  logic imem_req, opnd_le, alu_le, rf_we, halted;
  logic [31:0] imem_addr, ir, pc, retired;
  logic imem_req2, opnd_le2, alu_le2, rf_we2, halted2;
  logic [31:0] imem_addr2, ir2, pc2, retired2;
  logic [2:0] strb;
  assign strb = {opnd_le, alu_le, rf_we};
  always #5 clk = ~clk;
  multicycle_ctrl #(.DWIDTH(32), .PC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .op_in(op_in), .rdst_id(rdst_id), .stall(stall),
    .opnd_le(opnd_le), .alu_le(alu_le), .rf_we(rf_we), .pc(pc), .halted(halted), .retired(retired)
  );
  multicycle_ctrl #(.DWIDTH(32), .PC_RESET(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir2), .op_in(op_in), .rdst_id(rdst_id), .stall(stall),
    .opnd_le(opnd_le2), .alu_le(alu_le2), .rf_we(rf_we2), .pc(pc2), .halted(halted2), .retired(retired2)
  );
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [4:0]  rd;
    int          waits;
    logic        stall_f;
    int          stall_d;
    int          stall_e;
    int          stall_w;
    logic        exp_rf;
  } vec_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] retired;
    logic        rf;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] pc_exp = 0, ret_exp = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic stage(input string name, input int n, input logic [2:0] exp);
    for (int s = 0; s < n; s++) begin
      stall = 1'b1;
      #1;
      chk({name, "_stalled"}, strb, 3'b000);
      tick();
    end
    stall = 1'b0;
    #1;
    chk({name, "_strobe"}, strb, exp);
  endtask
  task automatic fetch(input vec_t v);
    for (int w = 0; w <= v.waits; w++) begin
      imem_ack   = w == v.waits;
      imem_rdata = v.instr;
      stall      = v.stall_f;
      op_in      = v.op;
      rdst_id    = v.rd;
      #1;
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, pc_exp);
      chk("fetch_strobe", strb, 3'b000);
      tick();
    end
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    stall      = 1'b0;
    pc_exp     = pc_exp + 4;
  endtask
  task automatic run_instr(input vec_t v);
    exp_t e;
    fetch(v);
    ret_exp = ret_exp == 32'hFFFF_FFFF ? ret_exp : ret_exp + 1;
    sb.push_back('{pc: pc_exp, ir: v.instr, retired: ret_exp, rf: v.exp_rf});
    stage("decode", v.stall_d, 3'b100);
    chk("decode_ir", ir, v.instr);
    tick();
    stage("exec", v.stall_e, 3'b010);
    tick();
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sb.pop_front();
      stage("wb", v.stall_w, {2'b00, e.rf});
      tick();
      chk("wb_retired", retired, e.retired);
      chk("wb_pc", pc, e.pc);
      chk("wb_ir", ir, e.ir);
    end
  endtask
  vec_t tbl[6];
  vec_t hv;
  logic [31:0] ir_hold;
  initial begin
    tbl[0] = '{32'h0022_1820, 4'b0010, 5'd3,  0, 1'b0, 0, 0, 0, 1'b1};
    tbl[1] = '{32'h0085_1022, 4'b0110, 5'd2,  3, 1'b0, 0, 0, 0, 1'b1};
    tbl[2] = '{32'h0022_0020, 4'b0010, 5'd0,  0, 1'b0, 0, 0, 0, 1'b0};
    tbl[3] = '{32'h00A6_3824, 4'b0000, 5'd7,  0, 1'b0, 0, 5, 0, 1'b1};
    tbl[4] = '{32'h0062_482A, 4'b0111, 5'd9,  1, 1'b1, 2, 0, 3, 1'b1};
    tbl[5] = '{32'h00E8_F827, 4'b1100, 5'd31, 2, 1'b0, 0, 1, 0, 1'b1};
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; imem_rdata = '0; op_in = 4'b0010; rdst_id = 5'd1;
    repeat (2) tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_strobes", strb, 3'b000);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_pc2", pc2, 32'hFFFF_FFFC);
    rst = 1'b0;
    tick();
    chk("post_rst_req", imem_req, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_instr(tbl[i]);
      if (i == 0) chk("pc2_wrap", pc2, 32'h0);
    end
    hv = '{32'hFC00_0000, 4'b1111, 5'd4, 1, 1'b0, 0, 0, 0, 1'b0};
    fetch(hv);
    op_in = 4'b1111;
    #1;
    chk("halt_decode_strobe", strb, 3'b000);
    chk("halt_decode_halted", halted, 1'b0);
    tick();
    chk("halt_entered", halted, 1'b1);
    ir_hold = ir;
    chk("halt_ir", ir_hold, hv.instr);
    for (int c = 0; c < 20; c++) begin
      imem_ack = $urandom_range(0, 1) == 1;
      stall    = $urandom_range(0, 1) == 1;
      op_in    = 4'($urandom_range(0, 15));
      rdst_id  = 5'($urandom_range(0, 31));
      imem_rdata = $urandom;
      #1;
      chk("halt_req", imem_req, 1'b0);
      chk("halt_strobe", strb, 3'b000);
      chk("halt_pc", pc, pc_exp);
      chk("halt_retired", retired, ret_exp);
      chk("halt_stays", halted, 1'b1);
      tick();
    end
    chk("halt_ir_frozen", ir, ir_hold);
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("restart_pc", pc, 32'h0);
    chk("restart_halted", halted, 1'b0);
    chk("restart_retired", retired, 32'h0);
    chk("restart_req_low", imem_req, 1'b0);
    tick();
    pc_exp = 0; ret_exp = 0;
    run_instr(tbl[0]);
    chk("pre_midrst_pc", pc, 32'h4);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    #1;
    chk("midrst_pending_req", imem_req, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_req_low", imem_req, 1'b0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_ir", ir, 32'h0);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("late_ack_pc", pc, 32'h0);
    chk("late_ack_ir", ir, 32'h0);
    chk("late_ack_strobe", strb, 3'b000);
    pc_exp = 0; ret_exp = 0;
    run_instr(tbl[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
